// File: rtl/axi_ram_burst_if.sv
// AXI3-style bus bundle for the burst RAM: write address/data/response and read address/data channels.
interface axi_ram_burst_if #(
  parameter int unsigned WIDTH_ID = 2,
  parameter int unsigned WIDTH_DA = 32,
  parameter int unsigned WIDTH_AD = 32
);
  logic [WIDTH_ID-1:0]   S_AXI_AWID;
  logic [WIDTH_AD-1:0]   S_AXI_AWADDR;
  logic [3:0]            S_AXI_AWLEN;
  logic [2:0]            S_AXI_AWSIZE;
  logic [1:0]            S_AXI_AWBURST;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;

  logic [WIDTH_DA-1:0]   S_AXI_WDATA;
  logic [WIDTH_DA/8-1:0] S_AXI_WSTRB;
  logic                  S_AXI_WLAST;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;

  logic [WIDTH_ID-1:0]   S_AXI_BID;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;

  logic [WIDTH_ID-1:0]   S_AXI_ARID;
  logic [WIDTH_AD-1:0]   S_AXI_ARADDR;
  logic [3:0]            S_AXI_ARLEN;
  logic [2:0]            S_AXI_ARSIZE;
  logic [1:0]            S_AXI_ARBURST;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;

  logic [WIDTH_ID-1:0]   S_AXI_RID;
  logic [WIDTH_DA-1:0]   S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RLAST;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_ram_burst.sv
// AXI3-style burst RAM slave: independent write (AW/W/B) and read (AR/R) FSMs over a byte-enabled word array.
module axi_ram_burst #(
  parameter int unsigned WIDTH_ID    = 2,
  parameter int unsigned WIDTH_DA    = 32,
  parameter int unsigned WIDTH_AD    = 32,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic           S_AXI_ACLK,
  input logic           S_AXI_ARESET,
  axi_ram_burst_if.slave s_axi
);
  localparam int unsigned NB  = WIDTH_DA / 8;
  localparam int unsigned LSB = $clog2(NB);
  localparam int unsigned IW  = $clog2(DEPTH_WORDS);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address of the following beat; WRAP keeps the upper bits and rolls the low bits inside the burst span.
  function automatic logic [WIDTH_AD-1:0] next_addr(input logic [WIDTH_AD-1:0] a,
                                                    input logic [3:0]          len,
                                                    input logic [1:0]          burst);
    logic [WIDTH_AD-1:0] mask;
    mask = WIDTH_AD'(((32'(len) + 32'd1) << LSB) - 32'd1);
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~mask) | ((a + WIDTH_AD'(NB)) & mask);
      default:     next_addr = a + WIDTH_AD'(NB);
    endcase
  endfunction

  function automatic logic req_err(input logic [2:0] size, input logic [3:0] len, input logic [1:0] burst);
    req_err = (size != 3'(LSB)) || (burst == BURST_RSVD) ||
              ((burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [WIDTH_AD-1:0] a);
    word_idx = a[LSB +: IW];
  endfunction

  logic [WIDTH_DA-1:0] mem [DEPTH_WORDS];

  // Write channel state
  logic [1:0]          w_state_q, w_state_d;
  logic [WIDTH_ID-1:0] w_id_q, w_id_d;
  logic [WIDTH_AD-1:0] w_addr_q, w_addr_d;
  logic [3:0]          w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]          w_burst_q, w_burst_d, bresp_q, bresp_d;
  logic                w_cfg_err_q, w_cfg_err_d, w_last_err_q, w_last_err_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                aw_hs, w_hs, b_hs, mem_we_c;

  // Read channel state
  logic [0:0]          r_state_q, r_state_d;
  logic [WIDTH_ID-1:0] r_id_q, r_id_d;
  logic [WIDTH_AD-1:0] r_addr_q, r_addr_d;
  logic [3:0]          r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]          r_burst_q, r_burst_d, rresp_q, rresp_d;
  logic                r_err_q, r_err_d;
  logic [WIDTH_DA-1:0] rdata_q, rdata_d;
  logic                rlast_q, rlast_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic                ar_hs, r_hs;

  always_comb begin : w_next
    w_state_d    = w_state_q;
    w_id_d       = w_id_q;
    w_addr_d     = w_addr_q;
    w_len_d      = w_len_q;
    w_cnt_d      = w_cnt_q;
    w_burst_d    = w_burst_q;
    w_cfg_err_d  = w_cfg_err_q;
    w_last_err_d = w_last_err_q;
    mem_we_c     = 1'b0;
    aw_hs        = s_axi.S_AXI_AWVALID && awready_q;
    w_hs         = s_axi.S_AXI_WVALID && wready_q;
    b_hs         = s_axi.S_AXI_BREADY && bvalid_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_id_d       = s_axi.S_AXI_AWID;
        w_addr_d     = s_axi.S_AXI_AWADDR;
        w_len_d      = s_axi.S_AXI_AWLEN;
        w_burst_d    = s_axi.S_AXI_AWBURST;
        w_cfg_err_d  = req_err(s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWLEN, s_axi.S_AXI_AWBURST);
        w_last_err_d = 1'b0;
        w_cnt_d      = 4'd0;
        w_state_d    = W_DATA;
      end
      W_DATA: if (w_hs) begin
        // A misplaced WLAST only flags the response; the counter alone ends the burst.
        mem_we_c = !w_cfg_err_q && !S_AXI_ARESET;
        if (s_axi.S_AXI_WLAST != (w_cnt_q == w_len_q)) w_last_err_d = 1'b1;
        w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
        w_cnt_d  = w_cnt_q + 4'd1;
        if (w_cnt_q == w_len_q) w_state_d = W_RESP;
      end
      W_RESP: if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = (w_cfg_err_d || w_last_err_d) ? RESP_SLVERR : RESP_OKAY;
  end

  always_comb begin : r_next
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    ar_hs     = s_axi.S_AXI_ARVALID && arready_q;
    r_hs      = s_axi.S_AXI_RREADY && rvalid_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_id_d    = s_axi.S_AXI_ARID;
        r_len_d   = s_axi.S_AXI_ARLEN;
        r_burst_d = s_axi.S_AXI_ARBURST;
        r_err_d   = req_err(s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARLEN, s_axi.S_AXI_ARBURST);
        r_cnt_d   = 4'd0;
        r_addr_d  = next_addr(s_axi.S_AXI_ARADDR, s_axi.S_AXI_ARLEN, s_axi.S_AXI_ARBURST);
        rdata_d   = r_err_d ? '0 : mem[word_idx(s_axi.S_AXI_ARADDR)];
        rresp_d   = r_err_d ? RESP_SLVERR : RESP_OKAY;
        rlast_d   = (s_axi.S_AXI_ARLEN == 4'd0);
        r_state_d = R_DATA;
      end
      R_DATA: if (r_hs) begin
        if (r_cnt_q == r_len_q) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          // r_addr_q already points at the beat being loaded here.
          r_cnt_d  = r_cnt_q + 4'd1;
          rdata_d  = r_err_q ? '0 : mem[word_idx(r_addr_q)];
          rlast_d  = (r_cnt_d == r_len_q);
          r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge S_AXI_ACLK) begin : regs
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;  w_id_q <= '0;  w_addr_q <= '0;  w_len_q <= '0;  w_cnt_q <= '0;
      w_burst_q <= '0;  w_cfg_err_q <= 1'b0;  w_last_err_q <= 1'b0;  bresp_q <= '0;
      awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;
      r_state_q <= R_IDLE;  r_id_q <= '0;  r_addr_q <= '0;  r_len_q <= '0;  r_cnt_q <= '0;
      r_burst_q <= '0;  r_err_q <= 1'b0;  rdata_q <= '0;  rresp_q <= '0;  rlast_q <= 1'b0;
      arready_q <= 1'b0;  rvalid_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;  w_id_q <= w_id_d;  w_addr_q <= w_addr_d;  w_len_q <= w_len_d;
      w_cnt_q <= w_cnt_d;  w_burst_q <= w_burst_d;  w_cfg_err_q <= w_cfg_err_d;
      w_last_err_q <= w_last_err_d;  bresp_q <= bresp_d;
      awready_q <= awready_d;  wready_q <= wready_d;  bvalid_q <= bvalid_d;
      r_state_q <= r_state_d;  r_id_q <= r_id_d;  r_addr_q <= r_addr_d;  r_len_q <= r_len_d;
      r_cnt_q <= r_cnt_d;  r_burst_q <= r_burst_d;  r_err_q <= r_err_d;  rdata_q <= rdata_d;
      rresp_q <= rresp_d;  rlast_q <= rlast_d;  arready_q <= arready_d;  rvalid_q <= rvalid_d;
    end
  end

  // Byte-enabled RAM write; a same-cycle read of this word still sees the old data.
  always_ff @(posedge S_AXI_ACLK) begin : ram_write
    if (mem_we_c) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (s_axi.S_AXI_WSTRB[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BID     = w_id_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RID     = r_id_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RLAST   = rlast_q;
endmodule

// File: tb/tb_axi_ram_burst.sv
// Directed self-checking bench for axi_ram_burst: bursts, strobes, wrap, backpressure, errors and reset abort.
module tb_axi_ram_burst;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] wr_vec [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  rd_id;
  int          rd_waits;
  logic [1:0]  wr_resp, wr_bid;

  axi_ram_burst_if #(.WIDTH_ID(2), .WIDTH_DA(32), .WIDTH_AD(32)) bus ();

  axi_ram_burst #(.WIDTH_ID(2), .WIDTH_DA(32), .WIDTH_AD(32), .DEPTH_WORDS(1024)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .s_axi       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input bit bad_last, input int bdelay);
    int t;
    bus.S_AXI_AWID = id;  bus.S_AXI_AWADDR = addr;  bus.S_AXI_AWLEN = len;
    bus.S_AXI_AWSIZE = size;  bus.S_AXI_AWBURST = burst;  bus.S_AXI_AWVALID = 1'b1;
    t = 0;
    while (!bus.S_AXI_AWREADY && t < 20) begin @(posedge clk); #1; t++; end
    check("awready", bus.S_AXI_AWREADY, 1);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.S_AXI_WDATA  = wr_vec[i];
      bus.S_AXI_WSTRB  = strb;
      bus.S_AXI_WLAST  = (i == int'(len)) && !bad_last;
      bus.S_AXI_WVALID = 1'b1;
      t = 0;
      while (!bus.S_AXI_WREADY && t < 20) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST  = 1'b0;
    t = 0;
    while (!bus.S_AXI_BVALID && t < 20) begin @(posedge clk); #1; t++; end
    check("bvalid", bus.S_AXI_BVALID, 1);
    repeat (bdelay) begin
      @(posedge clk); #1;
      check("bvalid_hold", bus.S_AXI_BVALID, 1);
      check("awready_blocked", bus.S_AXI_AWREADY, 0);
    end
    wr_resp = bus.S_AXI_BRESP;
    wr_bid  = bus.S_AXI_BID;
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    check("bvalid_clear", bus.S_AXI_BVALID, 0);
    check("awready_after_b", bus.S_AXI_AWREADY, 1);
  endtask

  task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input logic [31:0] stall_data, input logic stall_last);
    int t;
    bus.S_AXI_ARID = id;  bus.S_AXI_ARADDR = addr;  bus.S_AXI_ARLEN = len;
    bus.S_AXI_ARSIZE = size;  bus.S_AXI_ARBURST = burst;  bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!bus.S_AXI_ARREADY && t < 20) begin @(posedge clk); #1; t++; end
    check("arready", bus.S_AXI_ARREADY, 1);
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    rd_waits = 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        bus.S_AXI_RREADY = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check("stall_rvalid", bus.S_AXI_RVALID, 1);
          check("stall_rdata", bus.S_AXI_RDATA, stall_data);
          check("stall_rlast", bus.S_AXI_RLAST, stall_last);
        end
      end
      bus.S_AXI_RREADY = 1'b1;
      t = 0;
      while (!bus.S_AXI_RVALID && t < 20) begin @(posedge clk); #1; t++; rd_waits++; end
      rd_data[i] = bus.S_AXI_RDATA;
      rd_resp[i] = bus.S_AXI_RRESP;
      rd_last[i] = bus.S_AXI_RLAST;
      rd_id      = bus.S_AXI_RID;
      @(posedge clk); #1;
    end
    bus.S_AXI_RREADY = 1'b0;
    check("rvalid_end", bus.S_AXI_RVALID, 0);
    check("arready_end", bus.S_AXI_ARREADY, 1);
  endtask

  initial begin
    int t;
    bus.S_AXI_AWID = '0;  bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWLEN = '0;  bus.S_AXI_AWSIZE = '0;
    bus.S_AXI_AWBURST = '0;  bus.S_AXI_AWVALID = 1'b0;  bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WLAST = 1'b0;  bus.S_AXI_WVALID = 1'b0;  bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARID = '0;  bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARLEN = '0;  bus.S_AXI_ARSIZE = '0;
    bus.S_AXI_ARBURST = '0;  bus.S_AXI_ARVALID = 1'b0;  bus.S_AXI_RREADY = 1'b0;

    // Reset: outputs all zero, then ready one cycle after release
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", bus.S_AXI_AWREADY, 0);
    check("rst_wready", bus.S_AXI_WREADY, 0);
    check("rst_bvalid", bus.S_AXI_BVALID, 0);
    check("rst_bid_bresp", {bus.S_AXI_BID, bus.S_AXI_BRESP}, 0);
    check("rst_arready", bus.S_AXI_ARREADY, 0);
    check("rst_rvalid", bus.S_AXI_RVALID, 0);
    check("rst_rdata", bus.S_AXI_RDATA, 0);
    check("rst_rid_rresp_rlast", {bus.S_AXI_RID, bus.S_AXI_RRESP, bus.S_AXI_RLAST}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_awready", bus.S_AXI_AWREADY, 1);
    check("post_rst_arready", bus.S_AXI_ARREADY, 1);
    check("post_rst_bvalid", bus.S_AXI_BVALID, 0);
    check("post_rst_rvalid", bus.S_AXI_RVALID, 0);

    // INCR write then read back
    wr_vec[0] = 32'h11111111; wr_vec[1] = 32'h22222222; wr_vec[2] = 32'h33333333; wr_vec[3] = 32'h44444444;
    do_write(2'd2, 32'h100, 4'd3, 3'd2, 2'b01, 4'hF, 1'b0, 0);
    check("incr_bresp", wr_resp, 2'b00);
    check("incr_bid", wr_bid, 2'd2);
    do_read(2'd1, 32'h100, 4'd3, 3'd2, 2'b01, -1, 32'h0, 1'b0);
    check("incr_rwaits", rd_waits, 0);
    check("incr_rid", rd_id, 2'd1);
    check("incr_d0", rd_data[0], 32'h11111111);
    check("incr_d1", rd_data[1], 32'h22222222);
    check("incr_d2", rd_data[2], 32'h33333333);
    check("incr_d3", rd_data[3], 32'h44444444);
    check("incr_last", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);
    check("incr_resp", {rd_resp[0], rd_resp[3]}, 4'b0000);

    // WSTRB partial write over zero
    wr_vec[0] = 32'h0;
    do_write(2'd0, 32'h40, 4'd0, 3'd2, 2'b01, 4'hF, 1'b0, 0);
    wr_vec[0] = 32'hAABBCCDD;
    do_write(2'd0, 32'h40, 4'd0, 3'd2, 2'b01, 4'h5, 1'b0, 0);
    check("strb_bresp", wr_resp, 2'b00);
    do_read(2'd0, 32'h40, 4'd0, 3'd2, 2'b01, -1, 32'h0, 1'b0);
    check("strb_data", rd_data[0], 32'h00BB00DD);
    check("strb_last", rd_last[0], 1);

    // WRAP read starting mid-span
    wr_vec[0] = 32'd1; wr_vec[1] = 32'd2; wr_vec[2] = 32'd3; wr_vec[3] = 32'd4;
    do_write(2'd3, 32'h100, 4'd3, 3'd2, 2'b01, 4'hF, 1'b0, 0);
    do_read(2'd3, 32'h108, 4'd3, 3'd2, 2'b10, -1, 32'h0, 1'b0);
    check("wrap_d0", rd_data[0], 32'd3);
    check("wrap_d1", rd_data[1], 32'd4);
    check("wrap_d2", rd_data[2], 32'd1);
    check("wrap_d3", rd_data[3], 32'd2);
    check("wrap_last", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);
    check("wrap_rid", rd_id, 2'd3);

    // R backpressure on beat 1 and B backpressure
    do_read(2'd2, 32'h100, 4'd3, 3'd2, 2'b01, 1, 32'd2, 1'b0);
    check("bp_d1", rd_data[1], 32'd2);
    check("bp_d3", rd_data[3], 32'd4);
    wr_vec[0] = 32'h7; wr_vec[1] = 32'h8; wr_vec[2] = 32'h9;
    do_write(2'd1, 32'h300, 4'd2, 3'd2, 2'b00, 4'hF, 1'b0, 4);
    check("bp_bresp", wr_resp, 2'b00);
    check("bp_bid", wr_bid, 2'd1);
    do_read(2'd0, 32'h300, 4'd0, 3'd2, 2'b01, -1, 32'h0, 1'b0);
    check("fixed_data", rd_data[0], 32'h9);

    // Unsupported size: no RAM update, SLVERR
    wr_vec[0] = 32'hDEADBEEF; wr_vec[1] = 32'hCAFEF00D;
    do_write(2'd2, 32'h100, 4'd1, 3'd1, 2'b01, 4'hF, 1'b0, 0);
    check("size_err_bresp", wr_resp, 2'b10);
    do_read(2'd0, 32'h100, 4'd1, 3'd2, 2'b01, -1, 32'h0, 1'b0);
    check("size_err_d0", rd_data[0], 32'd1);
    check("size_err_d1", rd_data[1], 32'd2);

    // Reserved burst type on read
    do_read(2'd1, 32'h100, 4'd3, 3'd2, 2'b11, -1, 32'h0, 1'b0);
    check("rsvd_data", {rd_data[0], rd_data[1], rd_data[2], rd_data[3]}, 0);
    check("rsvd_resp", {rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}, 8'b10101010);
    check("rsvd_last", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);

    // WLAST missing on the final beat: data still written, SLVERR
    wr_vec[0] = 32'h5; wr_vec[1] = 32'h6;
    do_write(2'd0, 32'h200, 4'd1, 3'd2, 2'b01, 4'hF, 1'b1, 0);
    check("wlast_err_bresp", wr_resp, 2'b10);
    do_read(2'd0, 32'h200, 4'd1, 3'd2, 2'b01, -1, 32'h0, 1'b0);
    check("wlast_err_d0", rd_data[0], 32'h5);
    check("wlast_err_d1", rd_data[1], 32'h6);

    // Reset at beat 2 of an 8-beat read aborts it
    bus.S_AXI_ARID = 2'd1;  bus.S_AXI_ARADDR = 32'h100;  bus.S_AXI_ARLEN = 4'd7;
    bus.S_AXI_ARSIZE = 3'd2;  bus.S_AXI_ARBURST = 2'b01;  bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!bus.S_AXI_ARREADY && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_beat2_data", bus.S_AXI_RDATA, 32'd3);
    rst = 1'b1;
    bus.S_AXI_RREADY = 1'b0;
    @(posedge clk); #1;
    check("abort_rvalid", bus.S_AXI_RVALID, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_rvalid_post", bus.S_AXI_RVALID, 0);
    check("abort_arready_post", bus.S_AXI_ARREADY, 1);
    do_read(2'd2, 32'h104, 4'd0, 3'd2, 2'b01, -1, 32'h0, 1'b0);
    check("abort_next_data", rd_data[0], 32'd2);
    check("abort_next_resp", rd_resp[0], 2'b00);
    check("abort_next_rid", rd_id, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_ram_burst.md
Name: axi_ram_burst

Overview:
- Parametrised AXI3-style slave RAM, the successor to the fixed 4-beat/32-bit scratch RAM on the core0 memory bus.
- Honours AxLEN (1-16 beats), AxBURST (FIXED/INCR/WRAP), WSTRB byte enables, and echoes AXI IDs.
- Supports RREADY/BREADY backpressure and reports SLVERR for unsupported requests.
- Read and write channels are independent and may run concurrently; it serves as the instruction/data backing store behind the core's AXI master.

Parameters:
- WIDTH_ID, 2, AXI ID width.
- WIDTH_DA, 32, data width in bits (32 or 64).
- WIDTH_AD, 32, address width in bits.
- DEPTH_WORDS, 1024, RAM depth in WIDTH_DA-wide words (power of two).

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  synchronous active-high reset.
- S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  WIDTH_ID/WIDTH_AD/4/3/2  write address.
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA/WSTRB/WLAST  in  WIDTH_DA/WIDTH_DA/8/1  write data.
- S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BID/BRESP  out  WIDTH_ID/2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  WIDTH_ID/WIDTH_AD/4/3/2; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RID/RDATA/RRESP/RLAST  out  WIDTH_ID/WIDTH_DA/2/1; S_AXI_RVALID out 1; S_AXI_RREADY in 1.

Behaviour:
- Reset (synchronous, active-high):
  - While S_AXI_ARESET=1, all outputs are 0. Both FSMs go to IDLE and counters clear.
  - RAM contents are not cleared.
  - Reset mid-burst aborts the burst: no BVALID/RVALID is issued and any partially written beats remain.
- Word index = addr[LSB +: log2(DEPTH_WORDS)], where LSB = log2(WIDTH_DA/8). Upper address bits are ignored, so the address aliases modulo the RAM size.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - AWREADY = (state==W_IDLE). On the AW handshake, latch ID, address, LEN, BURST and an error flag; go to W_DATA.
  - WREADY = (state==W_DATA). Each W handshake writes the bytes whose WSTRB bit is 1; bytes with WSTRB=0 are unchanged.
  - Beat counter runs 0..AWLEN. On the beat where count==AWLEN, go to W_RESP with BVALID=1, BID=latched ID.
  - BVALID holds until BREADY; on the handshake, return to W_IDLE.
  - Earliest AWREADY for the next burst is the cycle after the B handshake.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - ARREADY = (state==R_IDLE). On the AR handshake, latch fields and load RDATA with beat 0 on the next edge; RVALID=1 the cycle after acceptance.
  - RDATA/RID/RRESP/RLAST are held stable while RVALID=1 and RREADY=0.
  - On each R handshake, load the next beat in the same edge, giving a throughput of 1 beat/clock.
  - RLAST=1 exactly on beat ARLEN. After the last handshake, RVALID=0 and the FSM returns to R_IDLE; ARREADY is 1 the following cycle.
- Address sequencing per beat:
  - FIXED: address constant.
  - INCR: address + WIDTH_DA/8.
  - WRAP: increment, with the low bits wrapping inside a boundary of (LEN+1)*WIDTH_DA/8 bytes.
- Errors (SLVERR=2'b10; OKAY=2'b00):
  - AxSIZE != LSB, AxBURST==2'b11, or WRAP with LEN not in {1,3,7,15} sets the error flag.
  - Erroneous writes perform no RAM updates, still consume AWLEN+1 beats, and return BRESP=SLVERR.
  - Erroneous reads return RDATA=0 with RRESP=SLVERR on every beat, with RLAST still correct.
  - A WLAST value that disagrees with the beat counter sets the write error flag; RAM writes still occur, and the burst still ends on the counter.
- Simultaneous read and write to the same word in one cycle: the read returns the old data; the write takes effect on the following cycle.
- Channels never block each other; no ordering is required between reads and writes.

Test Plan:
- Reset: assert S_AXI_ARESET for 3 cycles -> all outputs 0; one cycle after release, AWREADY=ARREADY=1 and BVALID=RVALID=0.
- INCR write AWADDR=0x100, AWLEN=3, AWID=2, WDATA 0x11111111..0x44444444, WSTRB=0xF -> BVALID with BID=2, BRESP=0. Then INCR read ARADDR=0x100, ARLEN=3 -> 4 beats in 4 cycles, data 0x11111111..0x44444444, RLAST on beat 3 only, RID echoed.
- WSTRB: write 0xAABBCCDD to 0x40 with WSTRB=0x5 over prior 0x00000000 -> read returns 0x00BB00DD.
- WRAP read ARADDR=0x108, ARLEN=3 over words 0x100..0x10C holding 1,2,3,4 -> beats 3,4,1,2.
- Backpressure: hold RREADY=0 for 5 cycles mid-burst -> RDATA/RLAST stable throughout; hold BREADY=0 -> BVALID held and AWREADY stays 0.
- Errors: AWSIZE=1 with AWLEN=1 -> RAM unchanged and BRESP=2'b10. ARBURST=2'b11 -> RRESP=2'b10 and RDATA=0 on all beats. Reset at beat 2 of an 8-beat read -> RVALID=0 and the next AR is accepted normally.
